// File: rtl/ic0_bus_arbiter_pkg.sv
// Shared types and widths for the ic0 master-side bus arbiter.
// Counter widths cover the full legal RD_TIMEOUT / WR_GAP range.
package ic0_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   localparam int RD_TIMEOUT_MAX = 255;
   localparam int WR_GAP_MAX     = 7;
   localparam int RD_CNT_W       = $clog2(RD_TIMEOUT_MAX + 1);
   localparam int GAP_CNT_W      = $clog2(WR_GAP_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RD_WAIT,
      ST_WR_GAP,
      ST_RSP
   } arb_state_e;

   // Index width that stays legal for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ic0_bus_arbiter_if.sv
// ic0 master-side bus: write/read valid pulses with address/data out,
// OR-combined slave read ready/data back.
interface ic0_bus_arbiter_if;
   import ic0_arb_pkg::*;

   logic              ic0_c_axi_mst_wr_valid;
   logic              ic0_c_axi_mst_rd_valid;
   logic [ADDR_W-1:0] ic0_axi_mst_wr_addr;
   logic [DATA_W-1:0] ic0_axi_mst_wr_data;
   logic [ADDR_W-1:0] ic0_axi_mst_rd_addr;
   logic              ic0_c_axi_slv_rd_ready;
   logic [DATA_W-1:0] ic0_axi_slv_rd_data;

   modport master (
      output ic0_c_axi_mst_wr_valid,
      output ic0_c_axi_mst_rd_valid,
      output ic0_axi_mst_wr_addr,
      output ic0_axi_mst_wr_data,
      output ic0_axi_mst_rd_addr,
      input  ic0_c_axi_slv_rd_ready,
      input  ic0_axi_slv_rd_data
   );

   modport slave (
      input  ic0_c_axi_mst_wr_valid,
      input  ic0_c_axi_mst_rd_valid,
      input  ic0_axi_mst_wr_addr,
      input  ic0_axi_mst_wr_data,
      input  ic0_axi_mst_rd_addr,
      output ic0_c_axi_slv_rd_ready,
      output ic0_axi_slv_rd_data
   );

endinterface

// File: rtl/ic0_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or
// above ptr_i, wrapping modulo N.
module ic0_rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   int best;

   // Smallest wrapped distance from the pointer wins.
   always_comb begin
      idx_o = '0;
      best  = N;
      for (int j = 0; j < N; j++) begin
         if (req_i[j] && ((j - int'(ptr_i) + N) % N) < best) begin
            best  = (j - int'(ptr_i) + N) % N;
            idx_o = IW'(j);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/ic0_bus_arbiter.sv
// ic0 master-side bus arbiter: round-robin grant, single-cycle issue,
// read timeout and a post-write gap before the next access.
module ic0_bus_arbiter
   import ic0_arb_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int RD_TIMEOUT = 15,
   parameter int WR_GAP     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_wr,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   ic0_bus_arbiter_if.master       bus
);

   localparam int IW = idx_w(N_REQ);
   localparam logic [RD_CNT_W-1:0] TMO_LAST =
      RD_CNT_W'(RD_TIMEOUT - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST =
      GAP_CNT_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

   arb_state_e           state_q;
   logic [IW-1:0]        ptr_q;
   logic [IW-1:0]        win_q;
   logic                 wr_q;
   logic [RD_CNT_W-1:0]  rd_cnt_q;
   logic [GAP_CNT_W-1:0] gap_cnt_q;

   logic [N_REQ-1:0]     grant_q;
   logic [N_REQ-1:0]     rsp_valid_q;
   logic [DATA_W-1:0]    rsp_rdata_q;
   logic                 rsp_err_q;
   logic                 wr_valid_q;
   logic                 rd_valid_q;
   logic [ADDR_W-1:0]    wr_addr_q;
   logic [DATA_W-1:0]    wr_data_q;
   logic [ADDR_W-1:0]    rd_addr_q;

   logic [IW-1:0]        win_d;
   logic [IW-1:0]        ptr_d;
   logic                 any_d;
   logic                 win_wr_d;
   logic [ADDR_W-1:0]    win_addr_d;
   logic [DATA_W-1:0]    win_wdata_d;

   ic0_rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .idx_o (win_d),
      .any_o (any_d)
   );

   assign ptr_d       = IW'((int'(win_d) + 1) % N_REQ);
   assign win_wr_d    = req_wr[win_d];
   assign win_addr_d  = req_addr[int'(win_d)*ADDR_W +: ADDR_W];
   assign win_wdata_d = req_wdata[int'(win_d)*DATA_W +: DATA_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         wr_q        <= 1'b0;
         rd_cnt_q    <= '0;
         gap_cnt_q   <= '0;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         wr_valid_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_addr_q   <= '0;
      end else begin
         grant_q     <= '0;
         rsp_valid_q <= '0;
         wr_valid_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (any_d) begin
                  win_q   <= win_d;
                  wr_q    <= win_wr_d;
                  ptr_q   <= ptr_d;
                  grant_q <= N_REQ'(1) << win_d;
                  if (win_wr_d) begin
                     wr_valid_q <= 1'b1;
                     wr_addr_q  <= win_addr_d;
                     wr_data_q  <= win_wdata_d;
                  end else begin
                     rd_valid_q <= 1'b1;
                     rd_addr_q  <= win_addr_d;
                  end
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               rd_cnt_q  <= '0;
               gap_cnt_q <= '0;
               if (!wr_q) begin
                  state_q <= ST_RD_WAIT;
               end else if (WR_GAP == 0) begin
                  rsp_valid_q <= N_REQ'(1) << win_q;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  state_q     <= ST_RSP;
               end else begin
                  state_q <= ST_WR_GAP;
               end
            end
            ST_RD_WAIT: begin
               // Ready beats the timeout when both land together.
               if (bus.ic0_c_axi_slv_rd_ready) begin
                  rsp_valid_q <= N_REQ'(1) << win_q;
                  rsp_rdata_q <= bus.ic0_axi_slv_rd_data;
                  rsp_err_q   <= 1'b0;
                  state_q     <= ST_RSP;
               end else if (rd_cnt_q == TMO_LAST) begin
                  rsp_valid_q <= N_REQ'(1) << win_q;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  state_q     <= ST_RSP;
               end else begin
                  rd_cnt_q <= rd_cnt_q + 1'b1;
               end
            end
            ST_WR_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  rsp_valid_q <= N_REQ'(1) << win_q;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  state_q     <= ST_RSP;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            ST_RSP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant     = grant_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   assign bus.ic0_c_axi_mst_wr_valid = wr_valid_q;
   assign bus.ic0_c_axi_mst_rd_valid = rd_valid_q;
   assign bus.ic0_axi_mst_wr_addr    = wr_addr_q;
   assign bus.ic0_axi_mst_wr_data    = wr_data_q;
   assign bus.ic0_axi_mst_rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_ic0_bus_arbiter.sv
// Self-checking bench for ic0_bus_arbiter: transaction-timeline model,
// directed scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_ic0_bus_arbiter;

   localparam int N   = 2;
   localparam int TMO = 15;
   localparam int GAP = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_wr;
   logic [N*32-1:0] req_addr;
   logic [N*32-1:0] req_wdata;
   logic [N-1:0]    grant;
   logic [N-1:0]    rsp_valid;
   logic [31:0]     rsp_rdata;
   logic            rsp_err;

   ic0_bus_arbiter_if bus_if();

   ic0_bus_arbiter #(
      .N_REQ      (N),
      .RD_TIMEOUT (TMO),
      .WR_GAP     (GAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .grant     (grant),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // requester intent
   bit          p_v  [N];
   bit          p_wr [N];
   logic [31:0] p_a  [N];
   logic [31:0] p_d  [N];
   bit hold  = 0;
   bit rnd   = 0;
   bit stray = 0;

   // slave behaviour
   int          lat      = 1;
   int          ready_at = -1;
   logic [31:0] sdat     = '0;
   logic        slv_rdy;
   logic [31:0] slv_dat;

   // model: transaction timeline, t counts cycles since accept
   bit m_busy;
   bit m_wr;
   int m_t, m_rsp_t, m_win, m_ptr;
   logic [N-1:0] e_grant, e_rspv;
   logic [31:0]  e_rdata, e_wra, e_wrd, e_rda;
   logic         e_err, e_wrv, e_rdv;

   // observed events
   int          g_q[$];
   int          g_c[$];
   int          rsp_c[$];
   logic [31:0] rsp_d[$];
   bit          rsp_e[$];
   int          rd_cyc, wr_cyc;
   logic [31:0] rd_a_log, wr_a_log, wr_d_log;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_wr = 0; m_ptr = 0; m_win = 0;
      m_t = 0; m_rsp_t = -1;
      e_grant = '0; e_rspv = '0; e_rdata = '0; e_err = 0;
      e_wrv = 0; e_rdv = 0; e_wra = '0; e_wrd = '0; e_rda = '0;
   endtask

   task automatic sched_rsp(logic [31:0] d, logic e);
      e_rspv  = N'(1) << m_win;
      e_rdata = d;
      e_err   = e;
      m_rsp_t = m_t + 1;
   endtask

   task automatic model_step();
      int w;
      e_grant = '0; e_rspv = '0; e_wrv = 0; e_rdv = 0;
      if (rst) begin
         model_reset();
         return;
      end
      if (!m_busy) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && p_v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         if (w >= 0) begin
            m_busy = 1; m_win = w; m_wr = p_wr[w];
            m_ptr = (w + 1) % N; m_t = 1; m_rsp_t = -1;
            e_grant = N'(1) << w;
            if (m_wr) begin
               e_wrv = 1; e_wra = p_a[w]; e_wrd = p_d[w];
            end else begin
               e_rdv = 1; e_rda = p_a[w];
            end
         end
      end else begin
         if (m_t == m_rsp_t) m_busy = 0;
         else if (m_wr) begin
            if (m_t + 1 == 2 + GAP) sched_rsp('0, 1'b0);
         end else if (m_t >= 2) begin
            if (slv_rdy) sched_rsp(slv_dat, 1'b0);
            else if (m_t == 1 + TMO) sched_rsp('0, 1'b1);
         end
         m_t++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      chk("grant", 32'(grant), 32'(e_grant));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rspv));
      chk("wr_valid", 32'(bus_if.ic0_c_axi_mst_wr_valid), 32'(e_wrv));
      chk("rd_valid", 32'(bus_if.ic0_c_axi_mst_rd_valid), 32'(e_rdv));
      chk("wr_addr", bus_if.ic0_axi_mst_wr_addr, e_wra);
      chk("wr_data", bus_if.ic0_axi_mst_wr_data, e_wrd);
      chk("rd_addr", bus_if.ic0_axi_mst_rd_addr, e_rda);
      chk("rd_wr_excl", 32'(bus_if.ic0_c_axi_mst_rd_valid &
                            bus_if.ic0_c_axi_mst_wr_valid), 32'h0);
      if (e_rspv != '0) begin
         chk("rsp_rdata", rsp_rdata, e_rdata);
         chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            g_q.push_back(i);
            g_c.push_back(cyc);
            if (!hold) p_v[i] = 0;
         end
      end
      if (bus_if.ic0_c_axi_mst_rd_valid) begin
         rd_cyc = cyc; rd_a_log = bus_if.ic0_axi_mst_rd_addr;
         if (rnd) begin
            case ($urandom_range(7))
               0, 1, 2: lat = 1;
               3: lat = 2;
               4: lat = 4;
               5: lat = 14;
               6: lat = 15;
               default: lat = -1;
            endcase
            sdat = $urandom;
         end
         ready_at = (lat < 0) ? -1 : cyc + lat;
      end
      if (bus_if.ic0_c_axi_mst_wr_valid) begin
         wr_cyc = cyc;
         wr_a_log = bus_if.ic0_axi_mst_wr_addr;
         wr_d_log = bus_if.ic0_axi_mst_wr_data;
      end
      if (rsp_valid != '0) begin
         rsp_c.push_back(cyc); rsp_d.push_back(rsp_rdata);
         rsp_e.push_back(rsp_err);
      end
      if (rnd) begin
         for (int i = 0; i < N; i++) begin
            if (!p_v[i]) begin
               if ($urandom_range(3) == 0) begin
                  p_v[i] = 1; p_wr[i] = 1'($urandom_range(1));
                  p_a[i] = $urandom; p_d[i] = $urandom;
               end
            end else if ($urandom_range(40) == 0) p_v[i] = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         req_valid[i] = p_v[i];
         req_wr[i]    = p_wr[i];
         req_addr[i*32 +: 32]  = p_a[i];
         req_wdata[i*32 +: 32] = p_d[i];
      end
      slv_rdy = (ready_at == cyc) || stray ||
                (rnd && $urandom_range(9) == 0);
      slv_dat = !slv_rdy ? 32'h0 :
                (ready_at == cyc) ? sdat :
                32'hDEAD_0000 | 32'($urandom_range(255));
      bus_if.ic0_c_axi_slv_rd_ready = slv_rdy;
      bus_if.ic0_axi_slv_rd_data    = slv_dat;
      model_step();
   endtask

   task automatic arm(int i, bit wr, logic [31:0] a, logic [31:0] d);
      p_v[i] = 1; p_wr[i] = wr; p_a[i] = a; p_d[i] = d;
   endtask

   task automatic clear_logs();
      g_q.delete(); g_c.delete(); rsp_c.delete();
      rsp_d.delete(); rsp_e.delete();
      rd_cyc = -100; wr_cyc = -100;
   endtask

   task automatic wait_rsp(int n, int lim);
      int k = 0;
      while (rsp_c.size() < n && k < lim) begin
         tick(); k++;
      end
      if (rsp_c.size() < n) begin
         total++; bad++;
         $display("FAIL wait_rsp: got %0d responses want %0d", rsp_c.size(), n);
      end
   endtask

   task automatic settle();
      int k = 0;
      while (m_busy && k < 60) begin
         tick(); k++;
      end
      if (m_busy) begin
         total++; bad++;
         $display("FAIL settle: model still busy after %0d cycles", k);
      end
      tick();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         p_v[i] = 0; p_wr[i] = 0; p_a[i] = '0; p_d[i] = '0;
      end
      req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      slv_rdy = 0; slv_dat = '0;
      bus_if.ic0_c_axi_slv_rd_ready = 1'b0;
      bus_if.ic0_axi_slv_rd_data    = '0;
      model_reset();
      clear_logs();
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rd_valid", 32'(bus_if.ic0_c_axi_mst_rd_valid), 32'h0);
      chk("rst_wr_addr", bus_if.ic0_axi_mst_wr_addr, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      rst = 0;

      // single read, ready one cycle after the pulse
      clear_logs(); lat = 1; sdat = 32'h0000_000A;
      arm(0, 0, 32'h460, 0);
      wait_rsp(1, 40);
      chk("rd1_grant_idx", 32'(g_q.size() > 0 ? g_q[0] : -1), 32'd0);
      chk("rd1_addr", rd_a_log, 32'h460);
      chk("rd1_latency", 32'(rsp_c[0] - rd_cyc), 32'd2);
      chk("rd1_rdata", rsp_d[0], 32'hA);
      chk("rd1_err", 32'(rsp_e[0]), 32'd0);
      settle();

      // write then read: post-write gap before the read pulse
      clear_logs(); lat = 1; sdat = 32'h77;
      arm(0, 1, 32'h454, 32'h3);
      tick();
      arm(1, 0, 32'h460, 0);
      wait_rsp(2, 60);
      chk("wr_first", 32'(g_q.size() > 1 ? g_q[0] : -1), 32'd0);
      chk("rd_second", 32'(g_q.size() > 1 ? g_q[1] : -1), 32'd1);
      chk("wr_addr_log", wr_a_log, 32'h454);
      chk("wr_data_log", wr_d_log, 32'h3);
      chk("wr_rsp_delay", 32'(rsp_c[0] - wr_cyc), 32'd3);
      chk("wr_to_rd_gap", 32'(rd_cyc - wr_cyc), 32'd5);
      chk("rd2_rdata", rsp_d[1], 32'h77);
      settle();

      // round robin with both requesters held
      begin
         int k = 0;
         clear_logs(); lat = 1; sdat = 32'h5; hold = 1;
         arm(0, 0, 32'h100, 0); arm(1, 0, 32'h104, 0);
         while (g_q.size() < 4 && k < 100) begin
            tick(); k++;
         end
         hold = 0; p_v[0] = 0; p_v[1] = 0;
         settle();
         chk("rr_count", 32'(g_q.size()), 32'd4);
         for (int i = 0; i < 4; i++)
            chk("rr_order", 32'(g_q.size() > i ? g_q[i] : -1), 32'(i % 2));
         chk("rr_read_spacing", 32'(g_c[1] - g_c[0]), 32'd4);
      end

      // timeout, then ready on the last wait cycle
      clear_logs(); lat = -1;
      arm(0, 0, 32'h800, 0);
      wait_rsp(1, 60);
      chk("tmo_latency", 32'(rsp_c[0] - rd_cyc), 32'd16);
      chk("tmo_err", 32'(rsp_e[0]), 32'd1);
      chk("tmo_rdata", rsp_d[0], 32'h0);
      settle();
      clear_logs(); lat = 15; sdat = 32'h5A5A;
      arm(0, 0, 32'h804, 0);
      wait_rsp(1, 60);
      chk("edge_latency", 32'(rsp_c[0] - rd_cyc), 32'd16);
      chk("edge_err", 32'(rsp_e[0]), 32'd0);
      chk("edge_rdata", rsp_d[0], 32'h5A5A);
      settle();

      // stray ready while idle and during a write
      clear_logs(); stray = 1;
      repeat (5) tick();
      chk("stray_idle_rsp", 32'(rsp_c.size()), 32'd0);
      arm(0, 1, 32'h454, 32'h9);
      wait_rsp(1, 40);
      stray = 0;
      chk("stray_wr_delay", 32'(rsp_c[0] - wr_cyc), 32'd3);
      chk("stray_wr_rdata", rsp_d[0], 32'h0);
      chk("stray_wr_err", 32'(rsp_e[0]), 32'd0);
      settle();

      // async reset in RD_WAIT, late ready afterwards
      begin
         int k = 0;
         clear_logs(); lat = -1;
         arm(1, 0, 32'h808, 0);
         while (g_q.size() < 1 && k < 20) begin
            tick(); k++;
         end
         repeat (3) tick();
         rst = 1;
         #1;
         chk("arst_rd_addr", bus_if.ic0_axi_mst_rd_addr, 32'h0);
         chk("arst_wr_data", bus_if.ic0_axi_mst_wr_data, 32'h0);
         chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
         model_reset();
         p_v[0] = 0; p_v[1] = 0;
         stray = 1;
         repeat (2) tick();
         stray = 0;
         rst = 0;
         repeat (2) tick();
         chk("arst_no_rsp", 32'(rsp_c.size()), 32'd0);
         clear_logs(); lat = 1; sdat = 32'h33;
         arm(0, 0, 32'h10, 0); arm(1, 0, 32'h14, 0);
         wait_rsp(2, 40);
         chk("arst_ptr0", 32'(g_q.size() > 1 ? g_q[0] : -1), 32'd0);
         chk("arst_next", 32'(g_q.size() > 1 ? g_q[1] : -1), 32'd1);
         settle();
      end

      // randomized traffic against the model
      clear_logs(); rnd = 1;
      repeat (3000) tick();
      rnd = 0; p_v[0] = 0; p_v[1] = 0;
      settle();
      chk("rnd_activity", 32'(g_q.size() > 50), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
